// File: rtl/pokey_pwm_audio.sv
// Pokey audio output stage: mixes channel volumes per sample strobe, buffers the mixed duty
// values in a small FIFO and plays one per PWM period on a single registered output pin.
module pokey_pwm_audio #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned VOL_W      = 4,
   parameter int unsigned PWM_W      = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_CH*VOL_W-1:0]         ch_vol,
   input  logic                            ch_valid,
   input  logic                            enable,
   input  logic                            status_clr,
   output logic                            audio_out,
   output logic                            overflow,
   output logic                            underrun,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int unsigned SUM_W = VOL_W + $clog2(NUM_CH);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [SUM_W-1:0] sum;
   logic [PWM_W-1:0] duty_new;

   logic [PWM_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic [PWM_W-1:0] cnt_q, duty_q;
   logic             enable_q, audio_q, overflow_q, underrun_q;

   logic full, empty, boundary, pop, push, overflow_ev, underrun_ev;

   // Sum width is sized so the mix can never wrap; the duty is the sum left-aligned in PWM_W.
   always_comb begin
      sum = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         sum = sum + SUM_W'(ch_vol[i*VOL_W +: VOL_W]);
      end
      duty_new = PWM_W'(sum) << (PWM_W - SUM_W);
   end

   always_comb begin
      full        = (level_q == LVL_W'(FIFO_DEPTH));
      empty       = (level_q == '0);
      // The enable rising edge starts a period just like the counter wrap does.
      boundary    = enable & ((cnt_q == '1) | ((cnt_q == '0) & ~enable_q));
      pop         = boundary & ~empty;
      underrun_ev = boundary & empty;
      push        = ch_valid & (~full | pop);
      overflow_ev = ch_valid & full & ~pop;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= duty_new;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         cnt_q      <= '0;
         duty_q     <= '0;
         enable_q   <= 1'b0;
         audio_q    <= 1'b0;
         overflow_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         cnt_q    <= enable ? cnt_q + 1'b1 : '0;
         enable_q <= enable;
         audio_q  <= enable & (cnt_q < duty_q);
         if (pop) begin
            duty_q   <= mem[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
         overflow_q <= overflow_ev | (overflow_q & ~status_clr);
         underrun_q <= underrun_ev | (underrun_q & ~status_clr);
      end
   end

   assign audio_out  = audio_q;
   assign overflow   = overflow_q;
   assign underrun   = underrun_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_pokey_pwm_audio.sv
// Self-checking bench for pokey_pwm_audio: directed scenarios plus random traffic, all compared
// cycle by cycle against a queue-based behavioural model of the audio stage.
module tb_pokey_pwm_audio;

   localparam int PERIOD = 256;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst, ch_valid, enable, status_clr;
   logic [15:0] ch_vol;
   logic        audio_out, overflow, underrun;
   logic [2:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int q[$];
   int m_cnt, m_duty;
   bit m_en_prev, m_ovf, m_und, m_out;

   pokey_pwm_audio dut (
      .clk        (clk),
      .rst        (rst),
      .ch_vol     (ch_vol),
      .ch_valid   (ch_valid),
      .enable     (enable),
      .status_clr (status_clr),
      .audio_out  (audio_out),
      .overflow   (overflow),
      .underrun   (underrun),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   function automatic int mix(input logic [15:0] v);
      int s = 0;
      for (int i = 0; i < 4; i++) s += int'((v >> (4 * i)) & 16'hF);
      return s * 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      bit bnd, pop, ovf_ev, und_ev;
      int new_duty;
      if (rst) begin
         q.delete();
         m_cnt = 0; m_duty = 0; m_out = 0; m_ovf = 0; m_und = 0; m_en_prev = 0;
      end else begin
         bnd      = enable && (m_cnt == PERIOD - 1 || (m_cnt == 0 && !m_en_prev));
         pop      = bnd && q.size() > 0;
         und_ev   = bnd && q.size() == 0;
         new_duty = pop ? q[0] : m_duty;
         m_out    = enable && (m_cnt < m_duty);
         if (pop) void'(q.pop_front());
         ovf_ev = 0;
         if (ch_valid) begin
            if (q.size() < DEPTH) q.push_back(mix(ch_vol));
            else ovf_ev = 1;
         end
         m_ovf     = ovf_ev || (m_ovf && !status_clr);
         m_und     = und_ev || (m_und && !status_clr);
         m_duty    = new_duty;
         m_cnt     = enable ? (m_cnt + 1) % PERIOD : 0;
         m_en_prev = enable;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("audio_out", audio_out, m_out);
      chk("overflow", overflow, m_ovf);
      chk("underrun", underrun, m_und);
      chk("fifo_level", fifo_level, q.size());
   endtask

   // One PWM period's worth of clocks; optionally strobes one sample at index push_at.
   task automatic window(input int push_at, input logic [15:0] vol, output int hi);
      hi = 0;
      for (int i = 0; i < PERIOD; i++) begin
         ch_valid = (i == push_at);
         if (i == push_at) ch_vol = vol;
         step();
         if (audio_out === 1'b1) hi++;
      end
      ch_valid = 1'b0;
   endtask

   task automatic do_reset();
      enable = 1'b0; ch_valid = 1'b0; status_clr = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic push_one(input logic [15:0] vol);
      ch_vol = vol; ch_valid = 1'b1;
      step();
      ch_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      int exp_w[5];
      int guard;

      // Reset with random inputs on the bus
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ch_vol = 16'($urandom); ch_valid = 1'($urandom); enable = 1'($urandom);
         status_clr = 1'($urandom);
         step();
      end
      rst = 1'b0; ch_valid = 1'b0; enable = 1'b0; status_clr = 1'b0;
      step();
      chk("rst_audio", audio_out, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_level", fifo_level, 0);

      // Full-scale mix: 60 -> duty 240
      push_one(16'hFFFF);
      chk("mix_level", fifo_level, 1);
      enable = 1'b1;
      window(-1, 16'h0, hi);
      chk("mix_first_partial", hi, 239);
      window(-1, 16'h0, hi);
      chk("mix_240_a", hi, 240);
      window(10, 16'h0000, hi);
      chk("mix_240_b", hi, 240);
      window(-1, 16'h0, hi);
      chk("mix_zero_a", hi, 0);
      window(-1, 16'h0, hi);
      chk("mix_zero_b", hi, 0);

      // Overflow with enable low, then order check
      do_reset();
      push_one(16'h0005);
      push_one(16'h000A);
      push_one(16'h000F);
      push_one(16'h00AA);
      chk("ovf_pre_flag", overflow, 0);
      push_one(16'h00FA);
      chk("ovf_level", fifo_level, 4);
      chk("ovf_flag", overflow, 1);
      status_clr = 1'b1;
      step();
      status_clr = 1'b0;
      chk("ovf_cleared", overflow, 0);
      enable = 1'b1;
      exp_w = '{19, 40, 60, 80, 80};
      for (int w = 0; w < 5; w++) begin
         window(-1, 16'h0, hi);
         chk($sformatf("ovf_order_%0d", w), hi, exp_w[w]);
      end
      chk("ovf_tail_underrun", underrun, 1);

      // Sequence 1,2,3 then underrun hold, then a sum-8 sample
      do_reset();
      push_one(16'h0001);
      push_one(16'h0002);
      push_one(16'h0003);
      enable = 1'b1;
      exp_w[0:3] = '{3, 8, 12, 12};
      for (int w = 0; w < 4; w++) begin
         window(-1, 16'h0, hi);
         chk($sformatf("seq_%0d", w), hi, exp_w[w]);
      end
      chk("seq_underrun", underrun, 1);
      window(100, 16'h0008, hi);
      chk("seq_push_window", hi, 12);
      window(-1, 16'h0, hi);
      chk("seq_duty32", hi, 32);

      // Re-enable with an empty FIFO: underrun at the rising edge, duty repeated
      enable = 1'b0;
      for (int i = 0; i < 5; i++) step();
      status_clr = 1'b1;
      step();
      status_clr = 1'b0;
      chk("reen_cleared", underrun, 0);
      enable = 1'b1;
      window(-1, 16'h0, hi);
      chk("reen_underrun", underrun, 1);
      chk("reen_repeat", hi, 32);

      // Full FIFO with a push on the boundary cycle
      do_reset();
      enable = 1'b1;
      step();
      for (int i = 0; i < 4; i++) push_one(16'($urandom));
      chk("full_level", fifo_level, 4);
      guard = 0;
      while (m_cnt != PERIOD - 1 && guard < 2 * PERIOD) begin
         step();
         guard++;
      end
      chk("full_reach_boundary", m_cnt, PERIOD - 1);
      push_one(16'($urandom));
      chk("full_pop_overflow", overflow, 0);
      chk("full_pop_level", fifo_level, 4);
      push_one(16'($urandom));
      chk("full_drop_overflow", overflow, 1);
      chk("full_drop_level", fifo_level, 4);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 499) == 0);
         ch_valid   = ($urandom_range(0, 149) == 0);
         status_clr = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 799) == 0) enable = ~enable;
         ch_vol = 16'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
